// File: rtl/mac_simd_pipe.sv
// Three-stage signed multiply-accumulate with guard bits, saturation and a
// dual-lane SIMD mode. The accumulator lives only in the last stage.
module mac_simd_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned GB = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                stall,
  input  logic                in_valid,
  input  logic [2:0]          instruction,
  input  logic [DW-1:0]       multiplier,
  input  logic [DW-1:0]       multiplicand,
  output logic                out_valid,
  output logic [2*DW-1:0]     result,
  output logic [GB-1:0]       guard,
  output logic                ovf
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned AW = PW + GB;
  localparam int unsigned HW = DW / 2;
  localparam int unsigned HG = GB / 2;
  localparam int unsigned LW = DW + HG;

  typedef enum logic [2:0] {
    OP_CLR  = 3'b000,
    OP_MUL  = 3'b001,
    OP_MAC  = 3'b010,
    OP_SAT  = 3'b011,
    OP_NOP  = 3'b100,
    OP_MUL2 = 3'b101,
    OP_MAC2 = 3'b110,
    OP_SAT2 = 3'b111
  } op_e;

  localparam logic [AW-1:0] FULL_MAX = {{(GB + 1){1'b0}}, {(PW - 1){1'b1}}};
  localparam logic [AW-1:0] FULL_MIN = {{(GB + 1){1'b1}}, {(PW - 1){1'b0}}};
  localparam logic [LW-1:0] LANE_MAX = {{(HG + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic [LW-1:0] LANE_MIN = {{(HG + 1){1'b1}}, {(DW - 1){1'b0}}};

  // S1: operand/opcode capture
  logic          s1_valid;
  op_e           s1_op;
  logic [DW-1:0] s1_a;
  logic [DW-1:0] s1_b;

  // S2: registered products
  logic          s2_valid;
  op_e           s2_op;
  logic [PW-1:0] s2_full;
  logic [DW-1:0] s2_lp0;
  logic [DW-1:0] s2_lp1;

  // S3: accumulator
  logic [AW-1:0] acc;

  logic [PW-1:0] full_prod_c;
  logic [DW-1:0] lp0_c;
  logic [DW-1:0] lp1_c;
  logic [AW-1:0] acc_nxt;
  logic          ovf_nxt;

  // Lane clamp: returns {clipped, value}; in range when the bits above the
  // DW-bit signed window are all copies of its sign bit.
  function automatic logic [LW:0] lane_sat(input logic [LW-1:0] v);
    logic [HG:0] top;
    top = v[LW-1:DW-1];
    if ((&top) || !(|top)) lane_sat = {1'b0, v};
    else if (v[LW-1])      lane_sat = {1'b1, LANE_MIN};
    else                   lane_sat = {1'b1, LANE_MAX};
  endfunction

  always_comb begin
    full_prod_c = PW'($signed(s1_a)) * PW'($signed(s1_b));
    lp0_c       = DW'($signed(s1_a[HW-1:0])) * DW'($signed(s1_b[HW-1:0]));
    lp1_c       = DW'($signed(s1_a[DW-1:HW])) * DW'($signed(s1_b[DW-1:HW]));
  end

  logic [AW-1:0] full_ext;
  logic [LW-1:0] lane0, lane1, l0_ext, l1_ext, l0_nxt, l1_nxt;
  logic [LW:0]   l0_sat, l1_sat;
  logic [GB:0]   full_top;
  logic          dual;

  // Next accumulator / overflow from the S2 payload
  always_comb begin
    acc_nxt  = acc;
    ovf_nxt  = ovf;
    dual     = 1'b0;
    full_ext = AW'($signed(s2_full));
    full_top = acc[AW-1:PW-1];
    lane0    = {acc[PW+HG-1:PW], acc[DW-1:0]};
    lane1    = {acc[AW-1:PW+HG], acc[PW-1:DW]};
    l0_ext   = LW'($signed(s2_lp0));
    l1_ext   = LW'($signed(s2_lp1));
    l0_nxt   = lane0;
    l1_nxt   = lane1;
    l0_sat   = lane_sat(lane0);
    l1_sat   = lane_sat(lane1);
    case (s2_op)
      OP_CLR: begin
        acc_nxt = '0;
        ovf_nxt = 1'b0;
      end
      OP_MUL: acc_nxt = full_ext;
      OP_MAC: acc_nxt = acc + full_ext;
      OP_SAT: begin
        if (!((&full_top) || !(|full_top))) begin
          acc_nxt = acc[AW-1] ? FULL_MIN : FULL_MAX;
          ovf_nxt = 1'b1;
        end
      end
      OP_NOP: acc_nxt = acc;
      OP_MUL2: begin
        dual   = 1'b1;
        l0_nxt = l0_ext;
        l1_nxt = l1_ext;
      end
      OP_MAC2: begin
        dual   = 1'b1;
        l0_nxt = lane0 + l0_ext;
        l1_nxt = lane1 + l1_ext;
      end
      OP_SAT2: begin
        dual   = 1'b1;
        l0_nxt = l0_sat[LW-1:0];
        l1_nxt = l1_sat[LW-1:0];
        if (l0_sat[LW] || l1_sat[LW]) ovf_nxt = 1'b1;
      end
      default: acc_nxt = acc;
    endcase
    if (dual) acc_nxt = {l1_nxt[LW-1:DW], l0_nxt[LW-1:DW], l1_nxt[DW-1:0], l0_nxt[DW-1:0]};
  end

  // Pipeline registers; stall freezes every stage including outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_CLR;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_op     <= OP_CLR;
      s2_full   <= '0;
      s2_lp0    <= '0;
      s2_lp1    <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_op     <= op_e'(instruction);
      s1_a      <= multiplier;
      s1_b      <= multiplicand;
      s2_valid  <= s1_valid;
      s2_op     <= s1_op;
      s2_full   <= full_prod_c;
      s2_lp0    <= lp0_c;
      s2_lp1    <= lp1_c;
      out_valid <= s2_valid;
      if (s2_valid) begin
        acc <= acc_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

  assign result = acc[PW-1:0];
  assign guard  = acc[AW-1:PW];

endmodule

// File: tb/tb_mac_simd_pipe.sv
// Directed self-checking bench for mac_simd_pipe (DW=16, GB=8).
module tb_mac_simd_pipe;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        in_valid;
  logic [2:0]  instruction;
  logic [15:0] multiplier;
  logic [15:0] multiplicand;
  logic        out_valid;
  logic [31:0] result;
  logic [7:0]  guard;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] CLR = 3'b000, MUL = 3'b001, MAC = 3'b010, SAT = 3'b011,
                         NOP = 3'b100, MUL2 = 3'b101, MAC2 = 3'b110, SAT2 = 3'b111;

  mac_simd_pipe #(.DW(16), .GB(8)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .in_valid(in_valid),
    .instruction(instruction), .multiplier(multiplier), .multiplicand(multiplicand),
    .out_valid(out_valid), .result(result), .guard(guard), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] res;
    logic [7:0]  grd;
    logic        ov;
  } vec_t;

  typedef struct {
    logic       st;
    logic       v;
    logic [2:0] op;
  } cyc_t;

  vec_t vt[23];
  cyc_t cy[9];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one instruction and check latency, pulse width and outputs
  task automatic run_one(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] res, input logic [7:0] grd,
                         input logic ov);
    @(negedge clk);
    in_valid = 1'b1; instruction = op; multiplier = a; multiplicand = b;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, " early_valid"}, 40'(out_valid), 40'(1'b0));
    @(negedge clk);
    check({tag, " out_valid"}, 40'(out_valid), 40'(1'b1));
    check({tag, " result"}, 40'(result), 40'(res));
    check({tag, " guard"}, 40'(guard), 40'(grd));
    check({tag, " ovf"}, 40'(ovf), 40'(ov));
    @(negedge clk);
    check({tag, " pulse_end"}, 40'(out_valid), 40'(1'b0));
  endtask

  logic [31:0] snap_res;
  logic [7:0]  snap_grd;
  logic        snap_ov;
  int          pulses;

  initial begin
    vt[0]  = '{CLR,  16'h0000, 16'h0000, 32'h00000000, 8'h00, 1'b0};
    vt[1]  = '{MUL,  16'h7FFF, 16'h7FFF, 32'h3FFF0001, 8'h00, 1'b0};
    vt[2]  = '{MUL,  16'h8000, 16'h8000, 32'h40000000, 8'h00, 1'b0};
    vt[3]  = '{MAC,  16'h8000, 16'h8000, 32'h80000000, 8'h00, 1'b0};
    vt[4]  = '{MAC,  16'h8000, 16'h8000, 32'hC0000000, 8'h00, 1'b0};
    vt[5]  = '{MAC,  16'h8000, 16'h8000, 32'h00000000, 8'h01, 1'b0};
    vt[6]  = '{SAT,  16'h0000, 16'h0000, 32'h7FFFFFFF, 8'h00, 1'b1};
    vt[7]  = '{NOP,  16'h1234, 16'h5678, 32'h7FFFFFFF, 8'h00, 1'b1};
    vt[8]  = '{CLR,  16'h0000, 16'h0000, 32'h00000000, 8'h00, 1'b0};
    vt[9]  = '{MUL2, 16'h807F, 16'h8081, 32'h4000C0FF, 8'h0F, 1'b0};
    vt[10] = '{MAC2, 16'h807F, 16'h8081, 32'h800081FE, 8'h0F, 1'b0};
    vt[11] = '{MAC2, 16'h807F, 16'h8081, 32'hC00042FD, 8'h0F, 1'b0};
    vt[12] = '{SAT2, 16'h0000, 16'h0000, 32'h7FFF8000, 8'h0F, 1'b1};
    vt[13] = '{SAT2, 16'h0000, 16'h0000, 32'h7FFF8000, 8'h0F, 1'b1};
    vt[14] = '{MUL,  16'hFFFF, 16'h0001, 32'hFFFFFFFF, 8'hFF, 1'b1};
    vt[15] = '{SAT,  16'h0000, 16'h0000, 32'hFFFFFFFF, 8'hFF, 1'b1};
    vt[16] = '{MAC2, 16'h0101, 16'h0101, 32'h00000000, 8'h00, 1'b1};
    vt[17] = '{CLR,  16'h0000, 16'h0000, 32'h00000000, 8'h00, 1'b0};
    vt[18] = '{MAC,  16'h8000, 16'h7FFF, 32'hC0008000, 8'hFF, 1'b0};
    vt[19] = '{MAC,  16'h8000, 16'h7FFF, 32'h80010000, 8'hFF, 1'b0};
    vt[20] = '{MAC,  16'h8000, 16'h7FFF, 32'h40018000, 8'hFF, 1'b0};
    vt[21] = '{SAT,  16'h0000, 16'h0000, 32'h80000000, 8'hFF, 1'b1};
    vt[22] = '{CLR,  16'h0000, 16'h0000, 32'h00000000, 8'h00, 1'b0};

    // MUL, MAC, [stall x2 with in_valid toggling], MAC, drain
    cy[0] = '{1'b0, 1'b1, MUL};
    cy[1] = '{1'b0, 1'b1, MAC};
    cy[2] = '{1'b1, 1'b0, MAC};
    cy[3] = '{1'b1, 1'b1, CLR};
    cy[4] = '{1'b0, 1'b1, MAC};
    cy[5] = '{1'b0, 1'b0, NOP};
    cy[6] = '{1'b0, 1'b0, NOP};
    cy[7] = '{1'b0, 1'b0, NOP};
    cy[8] = '{1'b0, 1'b0, NOP};

    reset_n = 1'b0; stall = 1'b0; in_valid = 1'b0;
    instruction = CLR; multiplier = '0; multiplicand = '0;

    #13;
    check("rst result", 40'(result), 40'h0);
    check("rst guard", 40'(guard), 40'h0);
    check("rst ovf", 40'(ovf), 40'h0);
    check("rst out_valid", 40'(out_valid), 40'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle out_valid %0d", i), 40'(out_valid), 40'h0);
    end

    for (int i = 0; i < 23; i++)
      run_one($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].res, vt[i].grd, vt[i].ov);

    // Stall mid-stream
    pulses = 0;
    snap_res = '0; snap_grd = '0; snap_ov = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      stall = cy[i].st; in_valid = cy[i].v; instruction = cy[i].op;
      multiplier = 16'h8000; multiplicand = 16'h8000;
      @(posedge clk);
      #1;
      if (i == 1) begin
        snap_res = result; snap_grd = guard; snap_ov = out_valid;
      end
      if (cy[i].st) begin
        check($sformatf("stall%0d out_valid", i), 40'(out_valid), 40'(snap_ov));
        check($sformatf("stall%0d result", i), 40'(result), 40'(snap_res));
        check($sformatf("stall%0d guard", i), 40'(guard), 40'(snap_grd));
      end else if (out_valid) begin
        pulses++;
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    check("stall pulses", 40'(pulses), 40'd3);
    check("stall result", 40'(result), 40'hC0000000);
    check("stall guard", 40'(guard), 40'h00);

    // Reset with two instructions in flight
    @(negedge clk);
    in_valid = 1'b1; instruction = MUL; multiplier = 16'h7FFF; multiplicand = 16'h7FFF;
    @(negedge clk);
    instruction = MAC;
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst result", 40'(result), 40'h0);
    check("midrst guard", 40'(guard), 40'h0);
    check("midrst out_valid", 40'(out_valid), 40'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst flush %0d", i), 40'(out_valid), 40'h0);
    end
    check("midrst acc", 40'({guard, result}), 40'h0);
    run_one("post_rst", MUL, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
